// File: rtl/ram4k_bist.sv
// +----------------------------------------------------------------------------+
// | Module   : ram4k_bist                                                      |
// | Function : March-style write/read self-test initiator for the 4K x 8 RAM.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ram4k_bist #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] SEED     = 8'hA5,
  parameter int                READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              first_err_vld
);

  localparam int              c_depth      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] c_last       = (ADDR_W + 1)'(c_depth - 1);
  localparam logic [2:0]      c_drain_last = 3'(READ_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state, w_state;
  logic [ADDR_W:0]     r_a, w_a, w_a_inc;
  logic                r_we, w_we;
  logic [DATA_W-1:0]   r_din, w_din;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                r_pass, w_pass;
  logic [ADDR_W:0]     r_err, w_err;
  logic [ADDR_W-1:0]   r_ferr_addr, w_ferr_addr;
  logic                r_ferr_vld, w_ferr_vld;
  logic [2:0]          r_drain, w_drain;
  logic                w_pv0;
  logic                w_mis;

  // Stage 0 tracks the address currently on mem_addr; stage READ_LAT lines up with mem_dout.
  logic                r_pv    [0:READ_LAT];
  logic [DATA_W-1:0]   r_pexp  [0:READ_LAT];
  logic [ADDR_W-1:0]   r_paddr [0:READ_LAT];

  assign w_a_inc = r_a + 1'b1;
  assign w_mis   = r_pv[READ_LAT] && (mem_dout != r_pexp[READ_LAT]);

  always_comb begin
    w_state     = r_state;
    w_a         = r_a;
    w_we        = 1'b0;
    w_din       = r_din;
    w_busy      = r_busy;
    w_done      = r_done;
    w_pass      = r_pass;
    w_drain     = r_drain;
    w_pv0       = 1'b0;
    w_err       = r_err;
    w_ferr_addr = r_ferr_addr;
    w_ferr_vld  = r_ferr_vld;

    if (w_mis) begin
      if (r_err != '1) w_err = r_err + 1'b1;
      if (!r_ferr_vld) begin
        w_ferr_addr = r_paddr[READ_LAT];
        w_ferr_vld  = 1'b1;
      end
    end

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state     = S_WR;
          w_a         = '0;
          w_we        = 1'b1;
          w_din       = SEED;
          w_busy      = 1'b1;
          w_done      = 1'b0;
          w_pass      = 1'b0;
          w_err       = '0;
          w_ferr_addr = '0;
          w_ferr_vld  = 1'b0;
        end
      end
      S_WR: begin
        if (r_a == c_last) begin
          w_state = S_RD;
          w_a     = '0;
          w_pv0   = 1'b1;
        end else begin
          w_a   = w_a_inc;
          w_we  = 1'b1;
          w_din = w_a_inc[DATA_W-1:0] ^ SEED;
        end
      end
      S_RD: begin
        if (r_a == c_last) begin
          w_state = S_DRAIN;
          w_drain = '0;
        end else begin
          w_a   = w_a_inc;
          w_pv0 = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain == c_drain_last) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          // Include the compare that closes on this same edge.
          w_pass  = (w_err == '0);
        end else begin
          w_drain = r_drain + 3'd1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_we        <= 1'b0;
      r_din       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err       <= '0;
      r_ferr_addr <= '0;
      r_ferr_vld  <= 1'b0;
      r_drain     <= '0;
      for (int i = 0; i <= READ_LAT; i++) begin
        r_pv[i]    <= 1'b0;
        r_pexp[i]  <= '0;
        r_paddr[i] <= '0;
      end
    end else begin
      r_state     <= w_state;
      r_a         <= w_a;
      r_we        <= w_we;
      r_din       <= w_din;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_pass      <= w_pass;
      r_err       <= w_err;
      r_ferr_addr <= w_ferr_addr;
      r_ferr_vld  <= w_ferr_vld;
      r_drain     <= w_drain;
      r_pv[0]     <= w_pv0;
      r_pexp[0]   <= w_a[DATA_W-1:0] ^ SEED;
      r_paddr[0]  <= w_a[ADDR_W-1:0];
      for (int i = 1; i <= READ_LAT; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_pexp[i]  <= r_pexp[i-1];
        r_paddr[i] <= r_paddr[i-1];
      end
    end
  end

  assign mem_we         = r_we;
  assign mem_addr       = r_a[ADDR_W-1:0];
  assign mem_din        = r_din;
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err;
  assign first_err_addr = r_ferr_addr;
  assign first_err_vld  = r_ferr_vld;

endmodule

`default_nettype wire

// File: tb/tb_ram4k_bist.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_ram4k_bist                                                   |
// | Function : Self-checking bench for ram4k_bist with fault-injecting RAM.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ram4k_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start2;
  logic        mem_we, busy, done, pass, first_err_vld;
  logic [11:0] mem_addr, first_err_addr;
  logic [7:0]  mem_din, mem_dout;
  logic [12:0] err_count;
  logic        mem_we2, busy2, done2, pass2, first_err_vld2;
  logic [11:0] mem_addr2, first_err_addr2;
  logic [7:0]  mem_din2, mem_dout2;
  logic [12:0] err_count2;

  ram4k_bist dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_vld(first_err_vld)
  );

  ram4k_bist #(.READ_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_din(mem_din2), .mem_dout(mem_dout2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .first_err_addr(first_err_addr2), .first_err_vld(first_err_vld2)
  );

  // Fault injection applied on the read path of both RAM models.
  logic        f0_en = 1'b0, f1_en = 1'b0;
  logic [11:0] f0_addr = '0, f1_addr = '0;
  logic [7:0]  f0_and = 8'hFF, f0_or = 8'h00, f0_xor = 8'h00, f1_xor = 8'h00;

  function automatic logic [7:0] flt(input logic [11:0] a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (f0_en && a == f0_addr) r = ((r & f0_and) | f0_or) ^ f0_xor;
    if (f1_en && a == f1_addr) r = r ^ f1_xor;
    return r;
  endfunction

  logic [7:0] mem1 [0:4095];
  logic [7:0] mem2 [0:4095];
  logic [7:0] rd1, rd2a, rd2b;

  always @(posedge clk) begin
    if (mem_we) mem1[mem_addr] <= mem_din;
    rd1 <= flt(mem_addr, mem1[mem_addr]);
    if (mem_we2) mem2[mem_addr2] <= mem_din2;
    rd2a <= flt(mem_addr2, mem2[mem_addr2]);
    rd2b <= rd2a;
  end
  assign mem_dout  = rd1;
  assign mem_dout2 = rd2b;

  // Write-port monitor for the READ_LAT=1 instance.
  int          wr_cnt = 0, wr_bad = 0;
  logic [11:0] wr_next = '0;
  logic [7:0]  din_000 = '0, din_0ff = '0, din_100 = '0;

  always @(posedge clk) begin
    if (start && !busy && !rst) begin
      wr_cnt  = 0;
      wr_bad  = 0;
      wr_next = '0;
    end else if (mem_we) begin
      wr_cnt++;
      if (mem_addr !== wr_next || mem_din !== (wr_next[7:0] ^ 8'hA5)) wr_bad++;
      if (mem_addr == 12'h000) din_000 = mem_din;
      if (mem_addr == 12'h0FF) din_0ff = mem_din;
      if (mem_addr == 12'h100) din_100 = mem_din;
      wr_next++;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  typedef struct {
    logic [12:0] err;
    logic [11:0] faddr;
    logic        vld;
    logic        pass;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        e0;
    logic [11:0] a0;
    logic [7:0]  am, om, xm;
    logic        e1;
    logic [11:0] a1;
    logic [7:0]  x1;
    logic [12:0] err;
    logic [11:0] fa;
    logic        vld, ps;
    string       tag;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mkvec(input logic e0, input logic [11:0] a0, input logic [7:0] am,
                                 input logic [7:0] om, input logic [7:0] xm, input logic e1,
                                 input logic [11:0] a1, input logic [7:0] x1, input logic [12:0] err,
                                 input logic [11:0] fa, input logic vld, input logic ps, input string tag);
    vec_t v;
    v.e0 = e0; v.a0 = a0; v.am = am; v.om = om; v.xm = xm;
    v.e1 = e1; v.a1 = a1; v.x1 = x1;
    v.err = err; v.fa = fa; v.vld = vld; v.ps = ps; v.tag = tag;
    return v;
  endfunction

  task automatic push_exp(input logic [12:0] err, input logic [11:0] fa, input logic vld,
                          input logic ps, input int lat, input string tag);
    exp_t e;
    e.err = err; e.faddr = fa; e.vld = vld; e.pass = ps; e.lat = lat; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_res(input int lat, input logic [12:0] err, input logic [11:0] fa,
                           input logic vld, input logic ps, input logic bz);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, "_latency"}, 64'(lat), 64'(e.lat));
    chk({e.tag, "_err_count"}, 64'(err), 64'(e.err));
    chk({e.tag, "_first_err_addr"}, 64'(fa), 64'(e.faddr));
    chk({e.tag, "_first_err_vld"}, 64'(vld), 64'(e.vld));
    chk({e.tag, "_pass"}, 64'(ps), 64'(e.pass));
    chk({e.tag, "_busy"}, 64'(bz), 64'd0);
  endtask

  // Pulse start (or hold it until done) and count edges from the sampling edge to done.
  task automatic run1(input bit hold, input bit restart_chk, output int lat);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    if (restart_chk) begin
      chk("restart_done", 64'(done), 64'd0);
      chk("restart_err", 64'(err_count), 64'd0);
      chk("restart_vld", 64'(first_err_vld), 64'd0);
      chk("restart_busy", 64'(busy), 64'd1);
    end
    lat = -1;
    for (int n = 1; n <= 20000; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run2(output int lat);
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20000; n++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic set_faults(input vec_t v);
    f0_en = v.e0; f0_addr = v.a0; f0_and = v.am; f0_or = v.om; f0_xor = v.xm;
    f1_en = v.e1; f1_addr = v.a1; f1_xor = v.x1;
  endtask

  function automatic logic [49:0] outs1();
    return {mem_we, mem_addr, mem_din, busy, done, pass, err_count, first_err_addr, first_err_vld};
  endfunction

  initial begin
    int   lat;
    bit   seen_we;
    bit   hit;
    vec_t clean;

    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    clean = mkvec(0, 12'h000, 8'hFF, 8'h00, 8'h00, 0, 12'h000, 8'h00, 13'd0, 12'h000, 0, 1, "clean");
    vt.push_back(clean);
    vt.push_back(mkvec(1, 12'h123, 8'hFE, 8'h00, 8'h00, 0, 12'h000, 8'h00, 13'd0, 12'h000, 0, 1, "sa0_123"));
    vt.push_back(mkvec(1, 12'h123, 8'hFF, 8'h01, 8'h00, 0, 12'h000, 8'h00, 13'd1, 12'h123, 1, 0, "sa1_123"));
    vt.push_back(mkvec(1, 12'h010, 8'hFF, 8'h00, 8'hFF, 1, 12'hFFF, 8'hFF, 13'd2, 12'h010, 1, 0, "two_faults"));

    // Reset held for three edges with start low.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_outputs", 64'(outs1()), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_outputs", 64'(outs1()), 64'd0);

    foreach (vt[i]) begin
      set_faults(vt[i]);
      push_exp(vt[i].err, vt[i].fa, vt[i].vld, vt[i].ps, 8193, vt[i].tag);
      run1(1'b0, 1'b0, lat);
      check_res(lat, err_count, first_err_addr, first_err_vld, pass, busy);
      chk({vt[i].tag, "_writes"}, 64'(wr_cnt), 64'd4096);
      chk({vt[i].tag, "_bad_writes"}, 64'(wr_bad), 64'd0);
      if (i == 0) begin
        chk("din_000", 64'(din_000), 64'hA5);
        chk("din_0ff", 64'(din_0ff), 64'h5A);
        chk("din_100", 64'(din_100), 64'hA5);
      end
    end

    // Second start straight after a failing run: counters clear, full rerun.
    push_exp(13'd2, 12'h010, 1'b1, 1'b0, 8193, "rerun");
    run1(1'b0, 1'b1, lat);
    check_res(lat, err_count, first_err_addr, first_err_vld, pass, busy);

    // Abort during the write pass at address 0x064.
    set_faults(clean);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (mem_we && mem_addr == 12'h064) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("abort_reached_064", 64'(hit), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_outputs", 64'(outs1()), 64'd0);
    seen_we = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (mem_we) seen_we = 1'b1;
    end
    chk("abort_no_writes", 64'(seen_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean run with start held high throughout: exactly one pass.
    push_exp(13'd0, 12'h000, 1'b0, 1'b1, 8193, "held_start");
    run1(1'b1, 1'b0, lat);
    check_res(lat, err_count, first_err_addr, first_err_vld, pass, busy);
    chk("held_start_writes", 64'(wr_cnt), 64'd4096);

    // Two-cycle read latency instance.
    push_exp(13'd0, 12'h000, 1'b0, 1'b1, 8194, "lat2_clean");
    run2(lat);
    check_res(lat, err_count2, first_err_addr2, first_err_vld2, pass2, busy2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
